// File: rtl/ntt_pkg.sv
// ntt_pkg: shared Kyber NTT constants, types and modular add/sub helpers
package ntt_pkg;
  localparam int KYBER_Q = 3329;
  localparam int COEF_W = 12;
  localparam int TAG_W = 8;
  localparam int BARRETT_M = 5039;
  localparam int BARRETT_SHIFT = 24;
  localparam int PROD_W = 2 * COEF_W;
  localparam int MPROD_W = PROD_W + 12;
  localparam logic [COEF_W:0] Q_EXT = (COEF_W + 1)'(KYBER_Q);
  typedef enum logic {MODE_CT = 1'b0, MODE_GS = 1'b1} mode_e;
  typedef logic [COEF_W-1:0] coef_t;
  // (x + y) mod Q for x, y < Q: at most one subtraction of Q is needed
  function automatic coef_t mod_add(coef_t x, coef_t y);
    logic [COEF_W:0] s;
    logic [COEF_W:0] r;
    s = {1'b0, x} + {1'b0, y};
    r = s >= Q_EXT ? s - Q_EXT : s;
    return r[COEF_W-1:0];
  endfunction
  // (x - y) mod Q for x, y < Q: the 13-bit sign bit selects the +Q fix-up
  function automatic coef_t mod_sub(coef_t x, coef_t y);
    logic [COEF_W:0] d;
    logic [COEF_W:0] r;
    d = {1'b0, x} - {1'b0, y};
    r = d[COEF_W] ? d + Q_EXT : d;
    return r[COEF_W-1:0];
  endfunction
endpackage

// File: rtl/ntt_butterfly_if.sv
// ntt_butterfly_if: valid/ready operand and result bus of the butterfly
interface ntt_butterfly_if;
  import ntt_pkg::*;
  logic in_valid;
  logic in_ready;
  logic mode;
  coef_t a_in;
  coef_t b_in;
  coef_t zeta;
  logic [TAG_W-1:0] tag_in;
  logic out_valid;
  logic out_ready;
  coef_t a_out;
  coef_t b_out;
  logic [TAG_W-1:0] tag_out;
  modport master (
    output in_valid, mode, a_in, b_in, zeta, tag_in, out_ready,
    input in_ready, out_valid, a_out, b_out, tag_out
  );
  modport slave (
    input in_valid, mode, a_in, b_in, zeta, tag_in, out_ready,
    output in_ready, out_valid, a_out, b_out, tag_out
  );
endinterface

// File: rtl/barrett_reduce.sv
// barrett_reduce: two-stage p mod Q for p < Q^2 (quotient registered, remainder fixed combinationally)
module barrett_reduce
  import ntt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [PROD_W-1:0] p_i,
  output coef_t             r_o
);
  logic [MPROD_W-1:0] pm;
  logic [PROD_W-1:0] qq;
  logic [COEF_W:0] rem;
  coef_t qhat_d;
  coef_t qhat_q;
  logic [PROD_W-1:0] p_q;
  // quotient estimate never exceeds Q-1, so 12 bits hold it; p*M stays below 2^36
  always_comb begin
    pm = MPROD_W'(p_i) * MPROD_W'(BARRETT_M);
    qhat_d = COEF_W'(pm >> BARRETT_SHIFT);
  end
  // capture product and quotient estimate together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q <= '0;
      qhat_q <= '0;
    end else if (en_i) begin
      p_q <= p_i;
      qhat_q <= qhat_d;
    end
  end
  // estimate is short by at most one, so the remainder lies in [0, 2Q) and fits 13 bits
  always_comb begin
    qq = PROD_W'(qhat_q) * PROD_W'(KYBER_Q);
    rem = (COEF_W + 1)'(p_q - qq);
    r_o = rem >= Q_EXT ? COEF_W'(rem - Q_EXT) : COEF_W'(rem);
  end
endmodule

// File: rtl/ntt_butterfly.sv
// ntt_butterfly: 4-stage pipelined Kyber CT/GS butterfly with valid/ready flow control
module ntt_butterfly
  import ntt_pkg::*;
(
  input logic clk,
  input logic rst,
  ntt_butterfly_if.slave bus
);
  logic adv;
  logic v1_q, v2_q, v3_q, v4_q;
  mode_e m1_q, m2_q, m3_q;
  logic [TAG_W-1:0] t1_q, t2_q, t3_q, t4_q;
  coef_t ap1_d, mx1_d, ap1_q, mx1_q, z1_q, ap2_q, ap3_q, r3, a4_d, b4_d, a4_q, b4_q;
  logic [PROD_W-1:0] p2_q;
  assign adv = !v4_q || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = v4_q;
  assign bus.a_out = a4_q;
  assign bus.b_out = b4_q;
  assign bus.tag_out = t4_q;
  // GS adds/subtracts before the multiply; CT passes a and multiplies b
  always_comb begin
    ap1_d = bus.mode == MODE_GS ? mod_add(bus.a_in, bus.b_in) : bus.a_in;
    mx1_d = bus.mode == MODE_GS ? mod_sub(bus.a_in, bus.b_in) : bus.b_in;
  end
  // S1 and S2: input capture and 12x12 product, shifting only when the output can move
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      m1_q <= MODE_CT;
      t1_q <= '0;
      ap1_q <= '0;
      mx1_q <= '0;
      z1_q <= '0;
      v2_q <= 1'b0;
      m2_q <= MODE_CT;
      t2_q <= '0;
      ap2_q <= '0;
      p2_q <= '0;
    end else if (adv) begin
      v1_q <= bus.in_valid;
      m1_q <= mode_e'(bus.mode);
      t1_q <= bus.tag_in;
      ap1_q <= ap1_d;
      mx1_q <= mx1_d;
      z1_q <= bus.zeta;
      v2_q <= v1_q;
      m2_q <= m1_q;
      t2_q <= t1_q;
      ap2_q <= ap1_q;
      p2_q <= PROD_W'(mx1_q) * PROD_W'(z1_q);
    end
  end
  barrett_reduce u_barrett (
    .clk  (clk),
    .rst  (rst),
    .en_i (adv),
    .p_i  (p2_q),
    .r_o  (r3)
  );
  // CT finishes with add/sub of the reduced product; GS already has both results
  always_comb begin
    a4_d = m3_q == MODE_CT ? mod_add(ap3_q, r3) : ap3_q;
    b4_d = m3_q == MODE_CT ? mod_sub(ap3_q, r3) : r3;
  end
  // S3 side-band and S4 output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3_q <= 1'b0;
      m3_q <= MODE_CT;
      t3_q <= '0;
      ap3_q <= '0;
      v4_q <= 1'b0;
      t4_q <= '0;
      a4_q <= '0;
      b4_q <= '0;
    end else if (adv) begin
      v3_q <= v2_q;
      m3_q <= m2_q;
      t3_q <= t2_q;
      ap3_q <= ap2_q;
      v4_q <= v3_q;
      t4_q <= t3_q;
      a4_q <= a4_d;
      b4_q <= b4_d;
    end
  end
endmodule

// File: doc/ntt_butterfly.md
Name: ntt_butterfly

Overview:
- Pipelined Kyber NTT butterfly, directly downstream of the twiddle ROM: consumes the 12-bit zeta plus two coefficients and produces the updated coefficient pair modulo q = 3329.
- Supports forward Cooley-Tukey (CT) and inverse Gentleman-Sande (GS) modes.
- Accepts one butterfly per clock through a valid/ready handshake.
- Sits between the NTT control/address generator (coefficient RAM read, ROM lookup) and the coefficient RAM write-back.

Parameters:
- Q, 3329, Kyber modulus; all operands and results lie in [0, Q-1].
- W, 12, coefficient/zeta width.
- TAG_W, 8, width of the opaque tag carried alongside each operation (e.g. write-back address).
- BARRETT_M, 5039, floor(2^24 / Q), Barrett constant.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block can accept an operation this cycle.
- mode  in  1  0 = CT (forward), 1 = GS (inverse).
- a_in  in  W  coefficient a, must be < Q.
- b_in  in  W  coefficient b, must be < Q.
- zeta  in  W  twiddle factor from the ROM, must be < Q.
- tag_in  in  TAG_W  opaque tag, returned unchanged with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- a_out  out  W  result a', < Q.
- b_out  out  W  result b', < Q.
- tag_out  out  TAG_W  tag of the result.

Behaviour:
- Arithmetic, CT mode:
  - t = (zeta*b) mod Q
  - a' = (a+t) mod Q
  - b' = (a-t) mod Q
- Arithmetic, GS mode:
  - a' = (a+b) mod Q
  - b' = (zeta*((a-b) mod Q)) mod Q
- Modular add/sub: single conditional correction (+Q or -Q) on a 13-bit signed intermediate.
- Multiply: 24-bit product p.
- Barrett reduction:
  - qhat = (p*BARRETT_M) >> 24
  - r = p - qhat*Q, 13-bit
  - if r >= Q then r -= Q (exactly one correction is sufficient for p < Q^2).
- Pipeline: 4 register stages; latency exactly 4 cycles from accepted input to out_valid when unstalled; throughput 1 per cycle.
  - S1: register inputs; GS pre-add/pre-sub.
  - S2: 12x12 product.
  - S3: Barrett quotient product.
  - S4: remainder correction plus CT post-add/sub; output register.
- Mode, tag and the a-path operand travel with their stage's valid bit.
- Handshake: advance = !out_valid || out_ready; the whole pipeline shifts only when advance = 1.
  - in_ready = advance, combinational.
  - An input is accepted when in_valid && in_ready.
  - Bubbles propagate as stage valid = 0.
- Stall (out_valid=1, out_ready=0): all stages hold; outputs stable; in_ready=0. No data lost or duplicated.
- Simultaneous out_ready and in_valid with a full pipeline: the result is retired and the new input accepted in the same cycle.
- Reset (asynchronous, any time including mid-operation):
  - all stage valids = 0; out_valid = 0.
  - a_out = 0, b_out = 0, tag_out = 0.
  - in-flight operations are discarded.
  - in_ready = 1 from the first cycle after deassertion.
- Inputs >= Q: outputs undefined; no assertion inside the block.

Decomposition:
- Shared package ntt_pkg: KYBER_Q, COEF_W, BARRETT_M, BARRETT_SHIFT = 24, mode encodings MODE_CT/MODE_GS.
- Sub-module barrett_reduce: pipelined 24-bit -> 12-bit reduction spanning S3/S4, reused later by the pointwise multiplier.
- Modular add/sub kept inline.

Test Plan:
- CT, a=100, b=200, zeta=1729, tag=0x11 -> 4 cycles later a_out=3013, b_out=516, tag_out=0x11.
- GS, a=100, b=200, zeta=1729 -> a_out=300, b_out=208.
- CT corner, a=3328, b=3328, zeta=3328 -> a_out=0, b_out=3327; CT, a=5, b=7, zeta=1 -> a_out=12, b_out=3327.
- Streaming and backpressure: 20 back-to-back random ops, out_ready low for 3 cycles mid-stream -> in_ready drops, results in order, none lost or duplicated, all match a golden model.
- Reset with 3 ops in flight -> out_valid=0 immediately, no stale results afterward, the next op returns with 4-cycle latency.
- Random sweep of 10k ops, both modes -> outputs always < 3329 and match the golden model.
